dff_bank_ctrl: RTL

Sequencer that owns a bank of WIDTH flip-flops with asynchronous clear and preset pins, driving their per-bit clear, preset, data and enable lines. It accepts one command at a time over a valid/ready handshake: clear-all, preset-all, load-word or check-only. It times the clear/preset pulses and the settle interval, then reads the bank back and reports pass/fail. It sits between the test/config master and the flop bank in the register-bank test fabric.

---
 rtl/dff_bank_ctrl_if.sv | 36 +++
 rtl/dff_bank_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_ctrl_if.sv
// Command and status bus between the test master
// and the flop-bank sequencer.
interface dff_bank_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  busy,
    input  done,
    input  err,
    input  err_cnt
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output busy,
    output done,
    output err,
    output err_cnt
  );
endinterface

// File: rtl/dff_bank_ctrl.sv
// Sequencer for a bank of async clear/preset flops:
// pulses, loads, settles, reads back and scores.
module dff_bank_ctrl #(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr,
  dff_bank_ctrl_if.slave   cmd,
  output logic [WIDTH-1:0] bank_clr,
  output logic [WIDTH-1:0] bank_pre,
  output logic [WIDTH-1:0] bank_d,
  output logic             bank_en,
  input  logic [WIDTH-1:0] bank_q
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("dff_bank_ctrl: WIDTH out of range");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
    $error("dff_bank_ctrl: PULSE_CYCLES out of range");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("dff_bank_ctrl: SETTLE_CYCLES out of range");
  end

  localparam logic [1:0] OP_CHECK  = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    LOAD,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // A zero settle interval skips straight to readback.
  localparam state_t POST_STIM =
    (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] exp_q, exp_d;

  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [7:0]       err_cnt_q;
  logic             mismatch;

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.err_cnt   = err_cnt_q;

  assign mismatch = (bank_q != exp_q);

  // Sequencer state, cycle counter and latched command.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_CHECK;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
    end
  end

  // Next state; the expected value doubles as load data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    exp_d   = exp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d  = cmd.cmd_op;
          cnt_d = PULSE_LAST;
          unique case (1'b1)
            (cmd.cmd_op == OP_CLEAR): begin
              exp_d   = '0;
              state_d = PULSE;
            end
            (cmd.cmd_op == OP_PRESET): begin
              exp_d   = '1;
              state_d = PULSE;
            end
            (cmd.cmd_op == OP_LOAD): begin
              exp_d   = cmd.cmd_data;
              state_d = LOAD;
            end
            default: begin
              exp_d   = cmd.cmd_data;
              state_d = CHECK;
            end
          endcase
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = POST_STIM;
          cnt_d   = SETTLE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LOAD: begin
        state_d = POST_STIM;
        cnt_d   = SETTLE_LAST;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bank drives follow the next state so they line up
  // with the state cycles; reset cuts them at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bank_clr <= '0;
      bank_pre <= '0;
      bank_d   <= '0;
      bank_en  <= 1'b0;
    end else begin
      bank_clr <= (state_d == PULSE && op_d == OP_CLEAR)
                  ? '1 : '0;
      bank_pre <= (state_d == PULSE && op_d == OP_PRESET)
                  ? '1 : '0;
      bank_en  <= (state_d == LOAD);
      if (state_d == LOAD) begin
        bank_d <= exp_d;
      end
    end
  end

  // Handshake and status flags, scored on the CHECK cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == CHECK);
      if (state_q == CHECK) begin
        err_q <= mismatch;
        if (mismatch && err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule
